// File: rtl/req_arbiter8_if.sv
// req_arbiter8_if: client/resource handshake bundle for req_arbiter8.
//   en      : arbitration enable (client side -> arbiter)
//   req     : 8-bit request vector, req[i] held by client i
//   done    : current grantee finished
//   gnt     : one-hot registered grant
//   gnt_id  : binary index of the grantee, 0 when idle
//   gnt_vld : any grant active
//   timeout : one-cycle pulse when the hold budget revoked a grant
// master modport: the client/request side; slave modport: the arbiter.
interface req_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_id, gnt_vld, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_id, gnt_vld, timeout
  );
endinterface

// File: rtl/req_arbiter8.sv
// req_arbiter8: eight-requester arbiter for a single shared resource.
// Grants are registered and held until the grantee signals done, drops its
// request, arbitration is disabled, or the hold budget expires.
//
// Parameters:
//   MAX_HOLD : grant length limit in cycles (1..255), 0 = unlimited
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : req_arbiter8_if.slave (en/req/done in, gnt/gnt_id/gnt_vld/timeout out)
// Build option:
//   ARB_ROUND_ROBIN_EN : when defined, the last grantee becomes lowest
//                        priority; otherwise bit 7 always has highest priority.
module req_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  req_arbiter8_if.slave  bus
);

  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_id;
  logic       r_gnt_vld;
  logic       r_timeout;
  logic [7:0] r_hold_cnt;

  logic [2:0] w_win_id;
  logic       w_win_vld;
  logic       w_release_early;
  logic       w_hold_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] r_ptr;
`endif

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_win_id = '0;
`ifdef ARB_ROUND_ROBIN_EN
    // Lowest priority is the last grantee (r_ptr), highest is r_ptr-1.
    for (int unsigned k = 0; k < 8; k++) begin
      logic [2:0] w_idx;
      w_idx = r_ptr + 3'(k);
      if (bus.req[w_idx]) w_win_id = w_idx;
    end
`else
    for (int unsigned k = 0; k < 8; k++) begin
      if (bus.req[k]) w_win_id = 3'(k);
    end
`endif
  end

  assign w_win_vld       = |bus.req;
  assign w_release_early = !bus.en || bus.done || !bus.req[r_gnt_id];
  assign w_hold_hit      = (MAX_HOLD != 0) && (r_hold_cnt == LP_MAX_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.en && w_win_vld) begin
            r_state    <= GRANT;
            r_gnt      <= 8'(1) << w_win_id;
            r_gnt_id   <= w_win_id;
            r_gnt_vld  <= 1'b1;
            r_hold_cnt <= 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr      <= w_win_id;
`endif
          end
        end
        GRANT: begin
          if (w_release_early || w_hold_hit) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_gnt_vld  <= 1'b0;
            r_hold_cnt <= '0;
            // Only a budget expiry with no higher-precedence release pulses.
            r_timeout  <= !w_release_early;
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: self-checking bench for req_arbiter8 (MAX_HOLD = 4).
// Each vector sets rst/en/req/done, queues the outputs required after the
// next rising edge, and the popped expectation is compared #1 after it.
module tb_req_arbiter8;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb[$];

  req_arbiter8_if bus ();

  req_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic en, input logic [7:0] req,
                              input logic done, input logic [7:0] gnt,
                              input logic [2:0] id, input logic to);
    vec_t v;
    v.rst   = r;
    v.en    = en;
    v.req   = req;
    v.done  = done;
    v.e.gnt = gnt;
    v.e.id  = id;
    v.e.vld = (gnt != 8'h00);
    v.e.to  = to;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst      = v.rst;
    bus.en   = v.en;
    bus.req  = v.req;
    bus.done = v.done;
    sb.push_back(v.e);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    vec_t v[$];
    do_reset();
    v.push_back(mk(1, 1, 8'hFF, 0, 8'h00, 3'd0, 0));
    v.push_back(mk(1, 1, 8'hFF, 1, 8'h00, 3'd0, 0));
    foreach (v[i]) begin
      exp_t e, got;
      drive(v[i]);
      @(posedge clk); #1;
      e   = sb.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got gnt=%h id=%0d vld=%b to=%b, required gnt=%h id=%0d vld=%b to=%b",
                 i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
      end
    end
  endtask

  task automatic test_priority_done();
    vec_t v[$];
    do_reset();
    v.push_back(mk(0, 1, 8'h24, 0, 8'h20, 3'd5, 0));
    v.push_back(mk(0, 1, 8'h24, 0, 8'h20, 3'd5, 0));
    v.push_back(mk(0, 1, 8'h24, 0, 8'h20, 3'd5, 0));
    v.push_back(mk(0, 1, 8'h04, 1, 8'h00, 3'd0, 0));
    v.push_back(mk(0, 1, 8'h04, 0, 8'h04, 3'd2, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 8'h00, 3'd0, 0));
    v.push_back(mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0));
    foreach (v[i]) begin
      exp_t e, got;
      drive(v[i]);
      @(posedge clk); #1;
      e   = sb.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL priority_done[%0d]: got gnt=%h id=%0d vld=%b to=%b, required gnt=%h id=%0d vld=%b to=%b",
                 i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    do_reset();
    for (int c = 0; c < 4; c++) v.push_back(mk(0, 1, 8'h01, 0, 8'h01, 3'd0, 0));
    v.push_back(mk(0, 1, 8'h01, 0, 8'h00, 3'd0, 1));
    v.push_back(mk(0, 1, 8'h01, 0, 8'h01, 3'd0, 0));
    v.push_back(mk(0, 1, 8'h01, 0, 8'h01, 3'd0, 0));
    v.push_back(mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0));
    foreach (v[i]) begin
      exp_t e, got;
      drive(v[i]);
      @(posedge clk); #1;
      e   = sb.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL timeout[%0d]: got gnt=%h id=%0d vld=%b to=%b, required gnt=%h id=%0d vld=%b to=%b",
                 i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
      end
    end
  endtask

  task automatic test_no_preempt();
    vec_t v[$];
    do_reset();
    v.push_back(mk(0, 1, 8'h08, 0, 8'h08, 3'd3, 0));
    v.push_back(mk(0, 1, 8'h88, 0, 8'h08, 3'd3, 0));
    v.push_back(mk(0, 1, 8'h80, 1, 8'h00, 3'd0, 0));
    v.push_back(mk(0, 1, 8'h80, 0, 8'h80, 3'd7, 0));
    v.push_back(mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0));
    foreach (v[i]) begin
      exp_t e, got;
      drive(v[i]);
      @(posedge clk); #1;
      e   = sb.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL no_preempt[%0d]: got gnt=%h id=%0d vld=%b to=%b, required gnt=%h id=%0d vld=%b to=%b",
                 i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
      end
    end
  endtask

  task automatic test_disable_and_reset();
    vec_t v[$];
    do_reset();
    v.push_back(mk(0, 1, 8'h02, 0, 8'h02, 3'd1, 0));
    v.push_back(mk(0, 0, 8'h02, 0, 8'h00, 3'd0, 0));
    v.push_back(mk(0, 0, 8'hFF, 0, 8'h00, 3'd0, 0));
    v.push_back(mk(0, 0, 8'hFF, 0, 8'h00, 3'd0, 0));
    // Reset lands on the edge where the hold budget would otherwise expire.
    for (int c = 0; c < 4; c++) v.push_back(mk(0, 1, 8'h40, 0, 8'h40, 3'd6, 0));
    v.push_back(mk(1, 1, 8'h40, 0, 8'h00, 3'd0, 0));
    v.push_back(mk(0, 1, 8'h40, 0, 8'h40, 3'd6, 0));
    v.push_back(mk(0, 1, 8'h00, 0, 8'h00, 3'd0, 0));
    foreach (v[i]) begin
      exp_t e, got;
      drive(v[i]);
      @(posedge clk); #1;
      e   = sb.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL disable_reset[%0d]: got gnt=%h id=%0d vld=%b to=%b, required gnt=%h id=%0d vld=%b to=%b",
                 i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    do_reset();
    for (int g = 0; g < 9; g++) begin
      logic [2:0] id;
`ifdef ARB_ROUND_ROBIN_EN
      id = 3'(7 - (g % 8));
`else
      id = 3'd7;
`endif
      v.push_back(mk(0, 1, 8'hFF, 0, 8'(1) << id, id, 0));
      v.push_back(mk(0, 1, 8'hFF, 1, 8'h00, 3'd0, 0));
    end
    foreach (v[i]) begin
      exp_t e, got;
      drive(v[i]);
      @(posedge clk); #1;
      e   = sb.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got gnt=%h id=%0d vld=%b to=%b, required gnt=%h id=%0d vld=%b to=%b",
                 i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
      end
    end
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    test_reset();
    test_priority_done();
    test_timeout();
    test_no_preempt();
    test_disable_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

Eight-requester arbiter that shares a single downstream resource (bus, display port, ALU slot) among up to eight clients. It uses the team's 8-to-3 priority scheme, in which bit 7 has the highest priority. Grants are registered and held until the grantee finishes, drops its request, or exceeds a hold budget. An optional round-robin mode is available. The block sits between client request lines and the shared resource's select mux.

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles, range 1..255; 0 means unlimited hold.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: arbitration enable. When low, no grant is issued and any current grant is released.
- `req`  in  8: request vector; `req[i]` is held high by client i while it wants the resource.
- `done`  in  1: the current grantee has finished; sampled only in GRANT.
- `gnt`  out  8: one-hot grant, registered.
- `gnt_id`  out  3: binary index of the current grantee; 0 when no grant.
- `gnt_vld`  out  1: high while any grant is active (equivalent to `|gnt`).
- `timeout`  out  1: one-cycle pulse when a grant is revoked by the hold budget.

## Operation
- Reset values: state IDLE, `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `timeout`=0, hold counter=0, last-served pointer=0.
- The state machine has two states, IDLE and GRANT.
- **IDLE:**
  - If `en`=1 and `req`≠0, select the winner, latch it into `gnt`/`gnt_id`/`gnt_vld`, load hold counter=1, and go to GRANT.
  - Otherwise remain in IDLE with outputs zero.
- **Winner selection (fixed priority):** the highest set index of `req` wins, so 7 beats 6 … beats 0.
- **GRANT** releases at the edge where any of the following holds, checked in this precedence:
  1. `en`=0.
  2. `done`=1.
  3. `req[gnt_id]`=0.
  4. `MAX_HOLD`≠0, counter==`MAX_HOLD`, and the request is still high. This release also sets `timeout`=1 for the next cycle.
- On release: go to IDLE and clear `gnt`, `gnt_id`, `gnt_vld`, and the counter.
- If no release condition holds: the counter increments, saturating at 255, and the grant holds.
- Requests from other clients during GRANT are ignored and never preempt the grantee.
- The last-served pointer is updated to `gnt_id` on each grant.
- `timeout` is cleared at every edge unless it is set by condition 4 above.
- Reset asserted mid-grant returns the block to the reset values at that edge, with no `timeout` pulse.

## Timing
- Grant latency: `gnt` is visible one cycle after the edge at which `req` is sampled high in IDLE.
- Release latency: `gnt` falls at the edge that samples the release condition.
- Between consecutive grants, `gnt`=0 for exactly one cycle (the IDLE arbitration cycle). Back-to-back service of the same client is therefore two cycles apart at minimum.
- Minimum grant length is 1 cycle: `done` may be high in the first GRANT cycle.
- With `MAX_HOLD`=N, a never-finishing client holds `gnt` for exactly N cycles. `timeout` is then high during the following IDLE cycle.
- A `req` pulse that rises and falls entirely within GRANT is lost; clients must hold `req` until granted.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - **Defined:** rotating priority. After serving client i, the search order is i-1, i-2, …, 0, 7, …, i, so i becomes lowest priority. The pointer resets to 0, so the first order is 7..0, identical to fixed priority.
  - **Undefined:** the pointer logic is removed and fixed priority (7 highest) always applies.
  - The interface and timing are identical in both builds.

## Test plan
- Reset, then `req`=8'b0010_0100, `en`=1, `done` pulsed in the third GRANT cycle. Required: the cycle after sampling gives `gnt`=8'b0010_0000, `gnt_id`=5, `gnt_vld`=1. `gnt` drops after `done`, then one cycle later `gnt`=8'b0000_0100, `gnt_id`=2.
- `MAX_HOLD`=4, `req`=8'b0000_0001 held, `done`=0. Required: `gnt`=1 for exactly 4 cycles, then `timeout`=1 for one cycle with `gnt`=0, then a re-grant to client 0.
- During a grant to client 3, raise `req[7]`. Required: no preemption, `gnt_id` stays 3 until `done`, and the next grant goes to 7.
- Drop `en` mid-grant, or assert `rst` mid-grant. Required: `gnt`=0, `gnt_id`=0, `timeout`=0 after that edge. With `en` low and `req`=8'hFF, no grant is issued.
- With `ARB_ROUND_ROBIN_EN`, `req`=8'hFF held and `done` pulsed every grant. Required: grant sequence 7,6,5,4,3,2,1,0,7. Without the macro, every grant goes to 7.
